// File: rtl/icc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : icc_branch_unit
// Description : Consumer end of the ALU condition codes. Holds the 4-bit
//               integer condition code register (icc = {N,Z,V,C}). It
//               evaluates SPARC-style Bicc conditions and computes the
//               branch target. It also sequences the delay slot, including
//               annulment, and issues a one-cycle redirect pulse to fetch.
// Ports       : clk, rst_n        - clock, synchronous active-low reset
//               cc_we, Z/N/C/V    - ALU flag write strobe and flags
//               flush             - abort pending branch, no redirect
//               br_valid/br_ready - branch request handshake
//               br_cond, br_annul - Bicc condition field and annul bit
//               br_pc, br_disp    - branch address, signed word displacement
//               slot_done         - delay-slot instruction retired/squashed
//               icc               - condition code register {N,Z,V,C}
//               slot_annul        - squash the delay-slot instruction
//               redirect(_pc)     - one-cycle fetch redirect and its target
// Revision    : 1.0 - initial release
// ============================================================================
module icc_branch_unit #(
  parameter int DISP_W = 22,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cc_we,
  input  logic              Z,
  input  logic              N,
  input  logic              C,
  input  logic              V,
  input  logic              flush,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_cond,
  input  logic              br_annul,
  input  logic [PC_W-1:0]   br_pc,
  input  logic [DISP_W-1:0] br_disp,
  input  logic              slot_done,
  output logic [3:0]        icc,
  output logic              slot_annul,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc
);

  localparam int EXT_W = PC_W - DISP_W;
  localparam logic [3:0] COND_BA = 4'b1000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SLOT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        icc_q, icc_d;
  logic              taken_q, taken_d;
  logic [PC_W-1:0]   target_q, target_d;
  logic              slot_annul_q, slot_annul_d;
  logic              redirect_q, redirect_d;
  logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;

  logic [3:0]        flags_eff;
  logic              cond_base;
  logic              cond_taken;
  logic [PC_W-1:0]   disp_ext;
  logic [PC_W-1:0]   target_calc;

  // A branch accepted in the same cycle as a cc-setting op sees the new flags.
  assign flags_eff = cc_we ? {N, Z, V, C} : icc_q;

  // Bicc: the low three bits select a predicate; cond[3] inverts it, which
  // turns "never" into "always" and each test into its complement.
  always_comb begin
    cond_base = 1'b0;
    unique case (br_cond[2:0])
      3'd0: cond_base = 1'b0;
      3'd1: cond_base = flags_eff[2];
      3'd2: cond_base = flags_eff[2] | (flags_eff[3] ^ flags_eff[1]);
      3'd3: cond_base = flags_eff[3] ^ flags_eff[1];
      3'd4: cond_base = flags_eff[0] | flags_eff[2];
      3'd5: cond_base = flags_eff[0];
      3'd6: cond_base = flags_eff[3];
      3'd7: cond_base = flags_eff[1];
      default: cond_base = 1'b0;
    endcase
  end

  assign cond_taken = br_cond[3] ? ~cond_base : cond_base;

  // Word displacement -> byte offset; the add wraps silently at 2^PC_W.
  assign disp_ext    = {{EXT_W{br_disp[DISP_W-1]}}, br_disp} << 2;
  assign target_calc = br_pc + disp_ext;

  assign br_ready = (state_q == ST_IDLE) && !flush;

  always_comb begin
    state_d       = state_q;
    icc_d         = cc_we ? {N, Z, V, C} : icc_q;
    taken_d       = taken_q;
    target_d      = target_q;
    slot_annul_d  = slot_annul_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;

    if (flush) begin
      state_d      = ST_IDLE;
      slot_annul_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (br_valid) begin
            state_d  = ST_SLOT;
            taken_d  = cond_taken;
            target_d = target_calc;
            // BA,a annuls its slot even though it is taken; every other
            // annulling branch squashes the slot only when it falls through.
            if (!br_annul)
              slot_annul_d = 1'b0;
            else if (br_cond == COND_BA)
              slot_annul_d = 1'b1;
            else
              slot_annul_d = ~cond_taken;
          end
        end
        ST_SLOT: begin
          if (slot_done) begin
            state_d       = ST_IDLE;
            slot_annul_d  = 1'b0;
            redirect_d    = taken_q;
            redirect_pc_d = target_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      icc_q         <= 4'b0000;
      taken_q       <= 1'b0;
      target_q      <= '0;
      slot_annul_q  <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      icc_q         <= icc_d;
      taken_q       <= taken_d;
      target_q      <= target_d;
      slot_annul_q  <= slot_annul_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign icc         = icc_q;
  assign slot_annul  = slot_annul_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_icc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_icc_branch_unit
// Description : Self-checking bench for icc_branch_unit. Directed scenarios
//               followed by random traffic, every cycle compared against a
//               behavioural model of the branch unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icc_branch_unit;

  logic        clk;
  logic        rst_n;
  logic        cc_we;
  logic        Z, N, C, V;
  logic        flush;
  logic        br_valid;
  logic        br_ready;
  logic [3:0]  br_cond;
  logic        br_annul;
  logic [31:0] br_pc;
  logic [21:0] br_disp;
  logic        slot_done;
  logic [3:0]  icc;
  logic        slot_annul;
  logic        redirect;
  logic [31:0] redirect_pc;

  icc_branch_unit #(.DISP_W(22), .PC_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cc_we       (cc_we),
    .Z           (Z),
    .N           (N),
    .C           (C),
    .V           (V),
    .flush       (flush),
    .br_valid    (br_valid),
    .br_ready    (br_ready),
    .br_cond     (br_cond),
    .br_annul    (br_annul),
    .br_pc       (br_pc),
    .br_disp     (br_disp),
    .slot_done   (slot_done),
    .icc         (icc),
    .slot_annul  (slot_annul),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  bit          m_known  = 0;
  bit          m_inslot = 0;
  bit          m_taken  = 0;
  logic [31:0] m_target = 0;
  logic [3:0]  m_icc    = 0;
  bit          m_annul  = 0;
  bit          m_redir  = 0;
  logic [31:0] m_rpc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Truth of a Bicc condition given flags packed as {N,Z,V,C}.
  function automatic bit bicc(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, v, c, r;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (cond)
      4'h0: r = 0;
      4'h1: r = z;
      4'h2: r = z || (n != v);
      4'h3: r = (n != v);
      4'h4: r = c || z;
      4'h5: r = c;
      4'h6: r = n;
      4'h7: r = v;
      4'h8: r = 1;
      4'h9: r = !z;
      4'hA: r = !(z || (n != v));
      4'hB: r = (n == v);
      4'hC: r = !(c || z);
      4'hD: r = !c;
      4'hE: r = !n;
      default: r = !v;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] target_of(input logic [31:0] pc, input logic [21:0] d);
    longint sd;
    sd = longint'(d);
    if (sd >= 64'sd2097152) sd = sd - 64'sd4194304;
    return 32'(longint'(pc) + sd * 4);
  endfunction

  // One clock: check br_ready for the current inputs, advance model and DUT,
  // then compare every registered output.
  task automatic step();
    bit          n_inslot, n_taken, n_annul, n_redir, t;
    logic [31:0] n_target, n_rpc;
    logic [3:0]  n_icc, eff;
    #1;
    if (m_known) check("br_ready", 32'(br_ready), 32'(!m_inslot && !flush));
    n_inslot = m_inslot; n_taken = m_taken; n_target = m_target;
    n_annul = m_annul; n_rpc = m_rpc; n_redir = 0;
    eff   = cc_we ? {N, Z, V, C} : m_icc;
    n_icc = eff;
    if (!rst_n) begin
      n_inslot = 0; n_taken = 0; n_annul = 0; n_rpc = 0; n_icc = 0;
    end else if (flush) begin
      n_inslot = 0; n_annul = 0;
    end else if (!m_inslot && br_valid) begin
      t = bicc(br_cond, eff);
      n_taken  = t;
      n_target = target_of(br_pc, br_disp);
      n_annul  = !br_annul ? 0 : (br_cond == 4'h8) ? 1 : !t;
      n_inslot = 1;
    end else if (m_inslot && slot_done) begin
      n_inslot = 0; n_annul = 0; n_redir = m_taken; n_rpc = m_target;
    end
    @(posedge clk);
    #1;
    m_inslot = n_inslot; m_taken = n_taken; m_target = n_target;
    m_annul = n_annul; m_redir = n_redir; m_rpc = n_rpc; m_icc = n_icc;
    m_known = 1;
    check("icc", 32'(icc), 32'(m_icc));
    check("redirect", 32'(redirect), 32'(m_redir));
    check("slot_annul", 32'(slot_annul), 32'(m_annul));
    if (m_redir) check("redirect_pc", redirect_pc, m_rpc);
  endtask

  task automatic quiet();
    cc_we = 0; flush = 0; br_valid = 0; slot_done = 0;
  endtask

  task automatic set_flags(input logic [3:0] nzvc);
    cc_we = 1; N = nzvc[3]; Z = nzvc[2]; V = nzvc[1]; C = nzvc[0];
  endtask

  task automatic put_branch(input logic [3:0] cond, input logic a,
                            input logic [31:0] pc, input logic [21:0] d);
    br_valid = 1; br_cond = cond; br_annul = a; br_pc = pc; br_disp = d;
  endtask

  initial begin
    rst_n = 0; quiet(); Z = 0; N = 0; C = 0; V = 0;
    br_cond = 0; br_annul = 0; br_pc = 0; br_disp = 0;

    // 1: reset, icc load, reset again
    step();
    check("reset_rpc", redirect_pc, 32'h0);
    rst_n = 1;
    set_flags(4'b0100); step(); quiet();
    check("icc_load", 32'(icc), 32'h4);
    rst_n = 0; step(); rst_n = 1;
    check("icc_after_rst", 32'(icc), 32'h0);
    #1 check("ready_after_rst", 32'(br_ready), 32'h1);

    // 2: BE taken, a=0, slot_done two cycles later
    set_flags(4'b0100); step(); quiet();
    put_branch(4'h1, 0, 32'h0000_1000, 22'h000004); step(); quiet();
    check("be_annul", 32'(slot_annul), 32'h0);
    step(); step();
    slot_done = 1; step(); slot_done = 0;
    check("be_redir", 32'(redirect), 32'h1);
    check("be_rpc", redirect_pc, 32'h0000_1010);
    step();
    check("be_pulse_end", 32'(redirect), 32'h0);

    // 3: BNE,a taken with negative displacement; BE,a not taken
    set_flags(4'b0000); step(); quiet();
    put_branch(4'h9, 1, 32'h0000_1000, 22'h3FFFFF); step(); quiet();
    check("bne_annul", 32'(slot_annul), 32'h0);
    slot_done = 1; step(); slot_done = 0;
    check("bne_rpc", redirect_pc, 32'h0000_0FFC);
    put_branch(4'h1, 1, 32'h0000_2000, 22'h000010); step(); quiet();
    check("be_a_annul", 32'(slot_annul), 32'h1);
    slot_done = 1; step(); slot_done = 0;
    check("be_a_noredir", 32'(redirect), 32'h0);

    // 4: BA,a and BN,a with br_valid held through SLOT
    put_branch(4'h8, 1, 32'h0000_3000, 22'h000100); step();
    check("ba_annul", 32'(slot_annul), 32'h1);
    step(); step();
    br_valid = 0; slot_done = 1; step(); slot_done = 0;
    check("ba_redir", 32'(redirect), 32'h1);
    put_branch(4'h0, 1, 32'h0000_4000, 22'h000100); step();
    check("bn_annul", 32'(slot_annul), 32'h1);
    step(); step();
    br_valid = 0; slot_done = 1; step(); slot_done = 0;
    check("bn_noredir", 32'(redirect), 32'h0);

    // 5: bypass of same-cycle flags; BG / BLE on zero flags
    set_flags(4'b0000); step(); quiet();
    set_flags(4'b1000); put_branch(4'h3, 0, 32'h100, 22'h2); step(); quiet();
    check("bl_icc", 32'(icc), 32'h8);
    slot_done = 1; step(); slot_done = 0;
    check("bl_bypass_taken", 32'(redirect), 32'h1);
    set_flags(4'b0000); put_branch(4'hA, 0, 32'h200, 22'h2); step(); quiet();
    slot_done = 1; step(); slot_done = 0;
    check("bg_taken", 32'(redirect), 32'h1);
    put_branch(4'h2, 0, 32'h300, 22'h2); step(); quiet();
    slot_done = 1; step(); slot_done = 0;
    check("ble_not_taken", 32'(redirect), 32'h0);

    // 6: flush mid-SLOT, then reset mid-SLOT
    put_branch(4'h8, 0, 32'h500, 22'h8); step(); quiet();
    flush = 1; br_valid = 1;
    #1 check("ready_in_flush", 32'(br_ready), 32'h0);
    step(); quiet();
    slot_done = 1; step(); slot_done = 0;
    check("flush_noredir", 32'(redirect), 32'h0);
    set_flags(4'b1111); put_branch(4'h8, 1, 32'h600, 22'h8); step(); quiet();
    rst_n = 0; step(); rst_n = 1;
    check("rst_mid_icc", 32'(icc), 32'h0);
    check("rst_mid_annul", 32'(slot_annul), 32'h0);
    slot_done = 1; step(); slot_done = 0;
    check("rst_mid_noredir", 32'(redirect), 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      cc_we     = ($urandom_range(0, 2) == 0);
      {N, Z, V, C} = 4'($urandom);
      br_valid  = $urandom_range(0, 1);
      br_cond   = 4'($urandom);
      br_annul  = $urandom_range(0, 1);
      br_pc     = $urandom;
      br_disp   = 22'($urandom);
      slot_done = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icc_branch_unit.md
Name: icc_branch_unit

Overview:
Consumer end of the ALU condition codes. Latches Z/N/C/V from cc-setting ALU operations into a 4-bit integer condition code register (icc). Evaluates SPARC-style Bicc branch conditions against icc and computes the branch target. Sequences the delay slot, including annulment, and issues a one-cycle redirect to fetch.

Parameters:
DISP_W, 22, width of the word displacement field
PC_W, 32, program counter / target width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
cc_we  input  1  write icc from the ALU flags this cycle
Z  input  1  ALU zero flag
N  input  1  ALU negative flag
C  input  1  ALU carry flag
V  input  1  ALU overflow flag
flush  input  1  abort any pending branch; no redirect
br_valid  input  1  branch request valid
br_ready  output  1  unit can accept a branch
br_cond  input  4  Bicc condition field
br_annul  input  1  annul bit of the branch
br_pc  input  PC_W  address of the branch instruction
br_disp  input  DISP_W  signed word displacement
slot_done  input  1  delay-slot instruction has retired or been squashed
icc  output  4  {N,Z,V,C} register
slot_annul  output  1  delay-slot instruction must be squashed (valid in SLOT)
redirect  output  1  one-cycle pulse: fetch must jump
redirect_pc  output  PC_W  jump target, valid while redirect=1

Behaviour:
- Reset (rst_n=0 at posedge): icc=0, state=IDLE, redirect=0, redirect_pc=0, slot_annul=0, internal taken=0. Reset has priority over everything, including mid-branch.
- icc register:
  - cc_we=1 loads {N,Z,V,C} at the edge, in any state.
  - Otherwise icc holds.
- Condition evaluation uses effective flags: the incoming Z/N/C/V if cc_we=1 in the accept cycle (bypass), else icc.
- Bicc conditions (cond -> taken):
  - 0000 never
  - 0001 Z
  - 0010 Z|(N^V)
  - 0011 N^V
  - 0100 C|Z
  - 0101 C
  - 0110 N
  - 0111 V
  - 1000 always
  - 1001 ~Z
  - 1010 ~(Z|(N^V))
  - 1011 ~(N^V)
  - 1100 ~(C|Z)
  - 1101 ~C
  - 1110 ~N
  - 1111 ~V
- Target: br_pc + (sign_extend(br_disp) << 2), computed modulo 2^PC_W; wrap-around is silent.
- FSM states: IDLE, SLOT.
  - IDLE:
    - br_ready=1.
    - br_valid&br_ready at edge T: register taken and target, set slot_annul, go to SLOT at T+1.
  - slot_annul rule:
    - If br_annul=0: slot_annul=0.
    - If br_annul=1 and cond=1000 (BA): slot_annul=1.
    - If br_annul=1 and any other cond: slot_annul = ~taken. This covers BN, which is never taken, so its slot is annulled.
  - SLOT:
    - br_ready=0; a branch in the delay slot is not accepted.
    - slot_annul is held.
    - On slot_done=1: next cycle state=IDLE, slot_annul=0, and redirect = registered taken (one-cycle pulse) with redirect_pc = target.
    - If not taken: no redirect pulse.
- Latency:
  - Accept at T gives slot_annul valid at T+1.
  - slot_done at cycle S gives redirect at S+1.
  - Minimum accept-to-redirect is 2 cycles (slot_done at T+1).
  - br_ready returns at S+1, the same cycle as redirect. A new branch may be accepted then.
- flush=1 (rst_n=1):
  - Next state=IDLE, redirect=0, slot_annul=0.
  - A br_valid in the same cycle is not accepted (br_ready forced 0 while flush=1).
  - icc is unaffected; cc_we still applies.
- slot_done while in IDLE: ignored.
- cc_we during SLOT updates icc; it never changes an already-evaluated branch.
- All outputs are registered except br_ready, which is decoded from state and flush.

Test Plan:
1. Reset, then cc_we=1 with Z=1,N=0,C=0,V=0 -> icc=4'b0100 next cycle. Then rst_n=0 for one edge -> icc=0, br_ready=1, redirect=0.
2. icc=0100; branch BE (0001), a=0, br_pc=32'h0000_1000, disp=22'h000004 -> slot_annul=0 at T+1. slot_done at T+3 -> redirect=1 at T+4 for exactly one cycle, redirect_pc=32'h0000_1010.
3. icc=0; BNE (1001), a=1, disp=22'h3FFFFF (-1), br_pc=32'h0000_1000 -> taken, slot_annul=0, redirect_pc=32'h0000_0FFC. Separately, BE a=1 with Z=0 -> slot_annul=1 and no redirect after slot_done.
4. BA a=1 -> slot_annul=1 and redirect asserted. BN a=1 -> slot_annul=1 and no redirect. In both, br_ready=0 throughout SLOT even with br_valid held high.
5. Bypass: icc=0, same cycle cc_we=1 with N=1,V=0 and a BL (0011) accepted -> taken; icc=1000 afterwards. Separately, BG with N=0,V=0,Z=0 -> taken, and BLE -> not taken.
6. Accept BA, assert flush at T+1 -> IDLE at T+2, no redirect even if slot_done is pulsed later. br_ready=0 during the flush cycle. Separately, rst_n=0 mid-SLOT gives the same result plus icc=0.
